// File: rtl/sm4_pkg.sv
// -----------------------------------------------------------------------------
// sm4_pkg
// Shared constants and types for the SM4 key-expansion sequencer.
//   - FK0..FK3 system parameters XORed into the master key at load time
//   - rotate amounts of the key-schedule linear transform L'
//   - FSM state encoding (IDLE / PRIME / RUN)
//   - round count and a 32-bit rotate-left helper
// -----------------------------------------------------------------------------
package sm4_pkg;

  localparam int N_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  // L'(b) = b ^ (b <<< 13) ^ (b <<< 23)
  localparam int LP_ROT_A = 13;
  localparam int LP_ROT_B = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } ks_state_e;

  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// -----------------------------------------------------------------------------
// sm4_sbox
// Combinational SM4 S-box, one byte in, one byte out. Four copies form the
// bytewise tau substitution of the key schedule.
// Ports:
//   i_byte  input  8  byte to substitute
//   o_byte  output 8  S-box image of i_byte
// -----------------------------------------------------------------------------
module sm4_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// sm4_key_sched_ctrl
// SM4 key-expansion sequencer. Loads K0..K3 = MK ^ FK, drives the index bus of
// an external registered CK ROM, and produces one round key per cycle,
// rk0..rk31, on a streaming output.
//
// Parameters:
//   ROM_LATENCY  cycles from count_round_out changing to matching cki_in (>= 1)
//   RK_W         round-key width (always 32 for SM4)
//
// Ports:
//   clk              input   1    rising-edge clock
//   rst              input   1    synchronous active-high reset
//   start            input   1    begin expansion (honoured only in IDLE)
//   mk_in            input   128  master key, MK0 in [127:96]
//   busy             output  1    state != IDLE
//   done             output  1    one-cycle pulse alongside rk31
//   count_round_out  output  5    registered CK ROM index
//   cki_in           input   32   CK constant from the ROM
//   rk_out           output  32   round key
//   rk_valid         output  1    rk_out carries a new key this cycle
//   rk_idx           output  5    round index of rk_out
//   dbg_state        output  2    current FSM state (ks_state_e encoding)
//
// Optional build macro SM4_RK_STORE_EN adds a 32-entry round-key file:
//   rk_rd_idx   input   5    read index
//   rk_rd_data  output  32   registered read data (1-cycle latency)
//   rk_ready    output  1    set with done, cleared on start acceptance / rst
//
// Stream semantics: rk_out/rk_idx/rk_valid form a push-only stream. A key is
// transferred on every cycle rk_valid is 1; there is no ready/backpressure, so
// the consumer must take every key on the cycle it is presented.
//
// Timeline (start accepted at edge T): PRIME spans ROM_LATENCY cycles so the
// ROM pipeline is full with CK[0] when RUN begins. Round r of RUN therefore
// sees cki_in = CK[r] while count_round_out already points ROM_LATENCY ahead.
// -----------------------------------------------------------------------------
module sm4_key_sched_ctrl
  import sm4_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int RK_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    mk_in,
  output logic            busy,
  output logic            done,
  output logic [4:0]      count_round_out,
  input  logic [RK_W-1:0] cki_in,
  output logic [RK_W-1:0] rk_out,
  output logic            rk_valid,
  output logic [4:0]      rk_idx,
`ifdef SM4_RK_STORE_EN
  input  logic [4:0]      rk_rd_idx,
  output logic [RK_W-1:0] rk_rd_data,
  output logic            rk_ready,
`endif
  output logic [1:0]      dbg_state
);

  localparam int          PW         = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [PW-1:0] PRIME_LAST = PW'(ROM_LATENCY - 1);

  ks_state_e       r_state;
  ks_state_e       w_next_state;

  logic [RK_W-1:0] r_k0, r_k1, r_k2, r_k3;
  logic [PW-1:0]   r_prime;
  logic [4:0]      r_round;
  logic [4:0]      r_cnt;
  logic [RK_W-1:0] r_rk_out;
  logic [4:0]      r_rk_idx;
  logic            r_rk_valid;
  logic            r_done;

  logic            w_accept;
  logic            w_prime_last;
  logic            w_last_round;
  logic [RK_W-1:0] w_x;
  logic [RK_W-1:0] w_tau;
  logic [RK_W-1:0] w_lp;
  logic [RK_W-1:0] w_rk;

  // ---------------------------------------------------------------------------
  // Round function: rk = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK))
  // ---------------------------------------------------------------------------
  assign w_x = r_k1 ^ r_k2 ^ r_k3 ^ cki_in;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .i_byte (w_x[8*g +: 8]),
      .o_byte (w_tau[8*g +: 8])
    );
  end

  assign w_lp = w_tau ^ rol32(w_tau, LP_ROT_A) ^ rol32(w_tau, LP_ROT_B);
  assign w_rk = r_k0 ^ w_lp;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)        w_next_state = ST_PRIME;
      ST_PRIME: if (w_prime_last) w_next_state = ST_RUN;
      ST_RUN:   if (w_last_round) w_next_state = ST_IDLE;
      default:                    w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and decoded strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (r_state != ST_IDLE);
    dbg_state    = r_state;
    w_accept     = (r_state == ST_IDLE) && start;
    w_prime_last = (r_state == ST_PRIME) && (r_prime == PRIME_LAST);
    w_last_round = (r_state == ST_RUN) && (r_round == 5'(N_ROUNDS - 1));
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k0       <= '0;
      r_k1       <= '0;
      r_k2       <= '0;
      r_k3       <= '0;
      r_prime    <= '0;
      r_round    <= '0;
      r_cnt      <= '0;
      r_rk_out   <= '0;
      r_rk_idx   <= '0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_k0    <= mk_in[127:96] ^ FK0;
            r_k1    <= mk_in[95:64]  ^ FK1;
            r_k2    <= mk_in[63:32]  ^ FK2;
            r_k3    <= mk_in[31:0]   ^ FK3;
            r_cnt   <= '0;
            r_prime <= '0;
            r_round <= '0;
          end
        end
        ST_PRIME: begin
          r_cnt   <= r_cnt + 5'd1;
          r_prime <= r_prime + PW'(1);
          r_round <= '0;
        end
        ST_RUN: begin
          r_rk_out   <= w_rk;
          r_rk_idx   <= r_round;
          r_rk_valid <= 1'b1;
          r_k0       <= r_k1;
          r_k1       <= r_k2;
          r_k2       <= r_k3;
          r_k3       <= w_rk;
          r_round    <= r_round + 5'd1;
          // Index runs ahead by ROM_LATENCY and may wrap; the wrapped
          // fetches are never consumed. Park it at 0 once the run ends.
          if (w_last_round) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_round_out = r_cnt;
  assign rk_out          = r_rk_out;
  assign rk_idx          = r_rk_idx;
  assign rk_valid        = r_rk_valid;
  assign done            = r_done;

`ifdef SM4_RK_STORE_EN
  // ---------------------------------------------------------------------------
  // Round-key file: written as each key is issued, never cleared by reset.
  // ---------------------------------------------------------------------------
  logic [RK_W-1:0] r_mem [N_ROUNDS];
  logic [RK_W-1:0] r_rd_data;
  logic            r_rk_ready;

  always_ff @(posedge clk) begin
    if (!rst && (r_state == ST_RUN)) begin
      r_mem[r_round] <= w_rk;
    end
  end

  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[rk_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rk_ready <= 1'b0;
    end else if (w_accept) begin
      r_rk_ready <= 1'b0;
    end else if (w_last_round) begin
      r_rk_ready <= 1'b1;
    end
  end

  assign rk_rd_data = r_rd_data;
  assign rk_ready   = r_rk_ready;
`endif

endmodule
